// File: rtl/bcd_score_keeper_if.sv
// ============================================================================
// Module      : bcd_score_keeper_if
// Description : Game-control and score-display signal bundle for the BCD
//               score keeper. Game control is the master; the keeper is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_score_keeper_if #(
    parameter int DIGITS = 4
);
    logic                  game_start;
    logic                  game_over;
    logic                  game_tick;
    logic                  bonus_valid;
    logic [3:0]            bonus_points;
    logic [4*DIGITS-1:0]   score;
    logic [4*DIGITS-1:0]   high_score;
    logic                  new_high;
    logic                  active;
    logic                  overflow;

    modport master (
        output game_start, game_over, game_tick, bonus_valid, bonus_points,
        input  score, high_score, new_high, active, overflow
    );

    modport slave (
        input  game_start, game_over, game_tick, bonus_valid, bonus_points,
        output score, high_score, new_high, active, overflow
    );
endinterface

`default_nettype wire

// File: rtl/bcd_score_keeper.sv
// ============================================================================
// Module      : bcd_score_keeper
// Description : Parametrised packed-BCD game score counter with tick/bonus
//               increments, saturate or wrap overflow and a session high score.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_score_keeper #(
    parameter int DIGITS      = 4,
    parameter int TICK_POINTS = 1,
    parameter int SATURATE    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_score_keeper_if.slave  bus
);

    localparam int                  c_width     = 4 * DIGITS;
    localparam logic [c_width-1:0]  c_all_nines = {DIGITS{4'h9}};
    localparam logic [4:0]          c_tick_add  = 5'(TICK_POINTS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_OVER   = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_width-1:0]   r_score;
    logic [c_width-1:0]   r_high_score;
    logic                 r_new_high;
    logic                 r_active;
    logic                 r_overflow;

    logic [3:0]           w_bonus;
    logic [4:0]           w_add;
    logic [c_width-1:0]   w_sum;
    logic [4:0]           w_carry;
    logic [4:0]           w_digit_sum;
    logic                 w_wrap;

    // Out-of-range bonus codes clamp to the largest BCD digit.
    assign w_bonus = (bus.bonus_points > 4'd9) ? 4'd9 : bus.bonus_points;
    assign w_add   = (bus.game_tick   ? c_tick_add       : 5'd0)
                   + (bus.bonus_valid ? {1'b0, w_bonus}  : 5'd0);

    // Digit 0 can receive up to 9+18=27, so carries of 0..2 ripple upward.
    always_comb begin
        w_carry     = w_add;
        w_sum       = '0;
        w_digit_sum = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_digit_sum = {1'b0, r_score[4*i +: 4]} + w_carry;
            if (w_digit_sum >= 5'd20) begin
                w_sum[4*i +: 4] = 4'(w_digit_sum - 5'd20);
                w_carry         = 5'd2;
            end else if (w_digit_sum >= 5'd10) begin
                w_sum[4*i +: 4] = 4'(w_digit_sum - 5'd10);
                w_carry         = 5'd1;
            end else begin
                w_sum[4*i +: 4] = w_digit_sum[3:0];
                w_carry         = 5'd0;
            end
        end
        w_wrap = (w_carry != 5'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_score      <= '0;
            r_high_score <= '0;
            r_new_high   <= 1'b0;
            r_active     <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            case (r_state)
                ST_ACTIVE: begin
                    if (bus.game_over) begin
                        r_state  <= ST_OVER;
                        r_active <= 1'b0;
                        if (r_score > r_high_score) begin
                            r_high_score <= r_score;
                            r_new_high   <= 1'b1;
                        end
                    end else if (bus.game_start) begin
                        r_score <= '0;
                    end else if (w_add != 5'd0) begin
                        r_overflow <= w_wrap;
                        if (w_wrap && (SATURATE != 0)) begin
                            r_score <= c_all_nines;
                        end else begin
                            r_score <= w_sum;
                        end
                    end
                end
                default: begin
                    if (bus.game_start) begin
                        r_state    <= ST_ACTIVE;
                        r_active   <= 1'b1;
                        r_score    <= '0;
                        r_new_high <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.score      = r_score;
    assign bus.high_score = r_high_score;
    assign bus.new_high   = r_new_high;
    assign bus.active     = r_active;
    assign bus.overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_bcd_score_keeper.sv
// ============================================================================
// Module      : tb_bcd_score_keeper
// Description : Directed self-checking bench; a saturating and a wrapping
//               instance share clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_score_keeper;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic s_ovf_seen;
    logic w_ovf_seen;

    bcd_score_keeper_if #(.DIGITS(4)) s_if ();
    bcd_score_keeper_if #(.DIGITS(4)) w_if ();

    bcd_score_keeper #(.DIGITS(4), .TICK_POINTS(1), .SATURATE(1)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if.slave)
    );

    bcd_score_keeper #(.DIGITS(4), .TICK_POINTS(1), .SATURATE(0)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (w_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic ov, input logic tk,
                       input logic bv, input logic [3:0] bp);
        s_if.game_start   = st;
        s_if.game_over    = ov;
        s_if.game_tick    = tk;
        s_if.bonus_valid  = bv;
        s_if.bonus_points = bp;
        @(posedge clk);
        #1;
        s_if.game_start   = 1'b0;
        s_if.game_over    = 1'b0;
        s_if.game_tick    = 1'b0;
        s_if.bonus_valid  = 1'b0;
        s_if.bonus_points = 4'd0;
        if (s_if.overflow) s_ovf_seen = 1'b1;
    endtask

    task automatic cyc_w(input logic st, input logic ov, input logic tk,
                         input logic bv, input logic [3:0] bp);
        w_if.game_start   = st;
        w_if.game_over    = ov;
        w_if.game_tick    = tk;
        w_if.bonus_valid  = bv;
        w_if.bonus_points = bp;
        @(posedge clk);
        #1;
        w_if.game_start   = 1'b0;
        w_if.game_over    = 1'b0;
        w_if.game_tick    = 1'b0;
        w_if.bonus_valid  = 1'b0;
        w_if.bonus_points = 4'd0;
        if (w_if.overflow) w_ovf_seen = 1'b1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        s_ovf_seen = 1'b0;
        w_ovf_seen = 1'b0;
        s_if.game_start = 1'b0; s_if.game_over = 1'b0; s_if.game_tick = 1'b0;
        s_if.bonus_valid = 1'b0; s_if.bonus_points = 4'd0;
        w_if.game_start = 1'b0; w_if.game_over = 1'b0; w_if.game_tick = 1'b0;
        w_if.bonus_valid = 1'b0; w_if.bonus_points = 4'd0;

        // Reset state
        rst_n = 1'b0;
        #12;
        chk("rst_score",    32'(s_if.score),      32'h0);
        chk("rst_high",     32'(s_if.high_score), 32'h0);
        chk("rst_new_high", 32'(s_if.new_high),   32'h0);
        chk("rst_active",   32'(s_if.active),     32'h0);
        chk("rst_overflow", 32'(s_if.overflow),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // game_over in IDLE is ignored
        cyc(0, 1, 0, 0, 4'd0);
        chk("idle_over_active", 32'(s_if.active), 32'h0);
        chk("idle_over_high",   32'(s_if.high_score), 32'h0);

        // Start and twelve ticks
        cyc(1, 0, 0, 0, 4'd0);
        chk("start_active", 32'(s_if.active), 32'h1);
        chk("start_score",  32'(s_if.score),  32'h0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0, 4'd0);
        chk("tick12_score",  32'(s_if.score),  32'h0012);
        chk("tick12_active", 32'(s_if.active), 32'h1);
        chk("tick12_no_ovf", 32'(s_ovf_seen),  32'h0);

        // Carry chain: 0x12 + 9*9 + 2 = 0x95, then tick + bonus 9 = 0x105
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 1, 4'd9);
        cyc(0, 0, 0, 1, 4'd2);
        chk("pre_carry_score", 32'(s_if.score), 32'h0095);
        cyc(0, 0, 1, 1, 4'd9);
        chk("carry_score", 32'(s_if.score), 32'h0105);

        // Restart in ACTIVE, then bonus 0xF clamps to 9
        cyc(1, 0, 0, 0, 4'd0);
        chk("restart_score", 32'(s_if.score), 32'h0);
        cyc(0, 0, 0, 1, 4'hF);
        chk("bonus_f_score", 32'(s_if.score), 32'h0009);

        // Game 1 ends at 0x42: 9 + 27 + 6
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 4'd9);
        cyc(0, 0, 0, 1, 4'd6);
        chk("g1_score", 32'(s_if.score), 32'h0042);
        cyc(0, 1, 1, 0, 4'd0);
        chk("g1_active",   32'(s_if.active),     32'h0);
        chk("g1_score_fz", 32'(s_if.score),      32'h0042);
        chk("g1_high",     32'(s_if.high_score), 32'h0042);
        chk("g1_new_high", 32'(s_if.new_high),   32'h1);

        // Game 2 ends at 0x30
        cyc(1, 0, 0, 0, 4'd0);
        chk("g2_new_high_clr", 32'(s_if.new_high), 32'h0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 4'd9);
        cyc(0, 0, 0, 1, 4'd3);
        chk("g2_score", 32'(s_if.score), 32'h0030);
        cyc(0, 1, 0, 0, 4'd0);
        chk("g2_high",     32'(s_if.high_score), 32'h0042);
        chk("g2_new_high", 32'(s_if.new_high),   32'h0);

        // Game 3 ties at 0x42: no update
        cyc(1, 0, 0, 0, 4'd0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 4'd9);
        cyc(0, 0, 0, 1, 4'd6);
        chk("g3_score", 32'(s_if.score), 32'h0042);
        cyc(0, 1, 0, 0, 4'd0);
        chk("g3_high",     32'(s_if.high_score), 32'h0042);
        chk("g3_new_high", 32'(s_if.new_high),   32'h0);

        // start + over + tick together in ACTIVE: over wins, score frozen
        cyc(1, 0, 0, 0, 4'd0);
        cyc(0, 0, 0, 1, 4'd7);
        chk("prio_pre_score", 32'(s_if.score), 32'h0007);
        cyc(1, 1, 1, 0, 4'd0);
        chk("prio_active",   32'(s_if.active),     32'h0);
        chk("prio_score",    32'(s_if.score),      32'h0007);
        chk("prio_high",     32'(s_if.high_score), 32'h0042);
        chk("prio_new_high", 32'(s_if.new_high),   32'h0);
        cyc(0, 0, 1, 0, 4'd0);
        chk("over_tick_ignored", 32'(s_if.score), 32'h0007);

        // Saturating instance: 999 * 10 = 9990, +5 = 9995, +9 saturates
        cyc(1, 0, 0, 0, 4'd0);
        s_ovf_seen = 1'b0;
        for (int i = 0; i < 999; i++) cyc(0, 0, 1, 1, 4'd9);
        chk("sat_9990", 32'(s_if.score), 32'h9990);
        cyc(0, 0, 0, 1, 4'd5);
        chk("sat_9995",   32'(s_if.score), 32'h9995);
        chk("sat_no_ovf", 32'(s_ovf_seen), 32'h0);
        cyc(0, 0, 0, 1, 4'd9);
        chk("sat_score", 32'(s_if.score),    32'h9999);
        chk("sat_ovf",   32'(s_if.overflow), 32'h1);
        cyc(0, 0, 1, 0, 4'd0);
        chk("sat_hold_score", 32'(s_if.score),    32'h9999);
        chk("sat_hold_ovf",   32'(s_if.overflow), 32'h1);
        cyc(0, 0, 0, 0, 4'd0);
        chk("sat_idle_score", 32'(s_if.score),    32'h9999);
        chk("sat_idle_ovf",   32'(s_if.overflow), 32'h0);
        cyc(0, 1, 0, 0, 4'd0);
        chk("sat_high",     32'(s_if.high_score), 32'h9999);
        chk("sat_new_high", 32'(s_if.new_high),   32'h1);

        // Wrapping instance: 9990 + 8 = 9998, tick + bonus 5 -> 0004
        cyc_w(1, 0, 0, 0, 4'd0);
        for (int i = 0; i < 999; i++) cyc_w(0, 0, 1, 1, 4'd9);
        cyc_w(0, 0, 0, 1, 4'd8);
        chk("wrap_9998",   32'(w_if.score), 32'h9998);
        chk("wrap_no_ovf", 32'(w_ovf_seen), 32'h0);
        cyc_w(0, 0, 1, 1, 4'd5);
        chk("wrap_score", 32'(w_if.score),    32'h0004);
        chk("wrap_ovf",   32'(w_if.overflow), 32'h1);
        cyc_w(0, 0, 0, 0, 4'd0);
        chk("wrap_ovf_pulse", 32'(w_if.overflow), 32'h0);

        // Async reset mid-game clears everything before the next edge
        cyc(1, 0, 0, 0, 4'd0);
        cyc(0, 0, 1, 1, 4'd3);
        chk("pre_rst_score", 32'(s_if.score), 32'h0004);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_score",    32'(s_if.score),      32'h0);
        chk("arst_high",     32'(s_if.high_score), 32'h0);
        chk("arst_new_high", 32'(s_if.new_high),   32'h0);
        chk("arst_active",   32'(s_if.active),     32'h0);
        chk("arst_overflow", 32'(s_if.overflow),   32'h0);
        chk("arst_w_score",  32'(w_if.score),      32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 1, 0, 4'd0);
        chk("post_rst_idle", 32'(s_if.score), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bcd_score_keeper.md
# bcd_score_keeper

Parametrised BCD score keeper for the game datapath. It is the successor to the fixed 4-digit +1-per-cycle score counter. It adds configurable digit count, per-frame and bonus increments, saturate/wrap overflow modes, and a session high-score register with a new-record flag. It sits between game control (start/over/tick pulses, bonus events) and the score display/serialiser.

## Interface
- `DIGITS`, default 4: number of BCD digits (1..8); score width is 4*DIGITS.
- `TICK_POINTS`, default 1: points added per `game_tick` while active (0..9).
- `SATURATE`, default 1: overflow mode. 1 clamps at all-9s; 0 wraps modulo 10^DIGITS.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `game_start`  in  1  one-cycle pulse; begins or restarts a game.
- `game_over`  in  1  one-cycle pulse; ends the current game.
- `game_tick`  in  1  end-of-frame pulse (60 Hz), one cycle wide.
- `bonus_valid`  in  1  bonus event qualifier for this cycle.
- `bonus_points`  in  4  bonus amount (BCD 0..9); values 10..15 are treated as 9.
- `score`  out  4*DIGITS  current score, packed BCD, digit 0 in bits [3:0].
- `high_score`  out  4*DIGITS  best final score since reset, packed BCD.
- `new_high`  out  1  level; set when the last finished game set a strictly higher record.
- `active`  out  1  high while in ACTIVE.
- `overflow`  out  1  one-cycle pulse when an add exceeds 10^DIGITS-1.

## Operation
- FSM states: IDLE, ACTIVE, OVER. `active` = (state == ACTIVE).
- IDLE/OVER + `game_start`: go to ACTIVE, `score` <= 0, `new_high` <= 0. `game_over` is ignored in these states.
- ACTIVE + `game_over`: go to OVER; the increments in that cycle are dropped and `score` is frozen.
  - If `score` > `high_score` (unsigned compare of the packed BCD vectors, strictly greater), then `high_score` <= `score` and `new_high` <= 1.
  - Otherwise `high_score` and `new_high` are unchanged.
- ACTIVE + `game_start` + `game_over` in the same cycle: `game_over` has priority (end the game, do the record compare). That `game_start` is discarded.
- ACTIVE + `game_start` alone: restart. `score` <= 0, no record compare, state stays ACTIVE.
- ACTIVE with neither pulse: add = (`game_tick` ? TICK_POINTS : 0) + (`bonus_valid` ? min(`bonus_points`, 9) : 0). The range is 0..18.
  - The add is applied as a BCD addition into digit 0, with decimal carry rippling through all DIGITS digits in one cycle.
  - Every digit of `score` is always a valid BCD value (0..9).
- Overflow, when the true sum is > 10^DIGITS-1:
  - `overflow` = 1 for that cycle, in both modes.
  - SATURATE=1: `score` <= all 9s. While `score` is held at all 9s, every further nonzero add pulses `overflow` again.
  - SATURATE=0: `score` <= sum mod 10^DIGITS.
- Add = 0 leaves `score` unchanged, with no `overflow`.
- `high_score` persists across games and is cleared only by `rst_n`.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset (asynchronous assert, synchronous deassert is the integrator's job):
  - state = IDLE
  - `score` = 0, `high_score` = 0
  - `new_high` = 0, `active` = 0, `overflow` = 0
- Latency is 1 cycle for everything below; each takes effect at the edge that samples the input:
  - tick/bonus sampled on edge N → `score` updated after edge N.
  - `game_over` sampled on edge N → `active` falls and `high_score`/`new_high` update after edge N.
  - `game_start` on edge N → `score` = 0 and `active` = 1 after edge N. The first increment is possible on edge N+1.
- `overflow` is high for exactly the cycle following the offending edge.
- Async reset mid-game clears everything immediately, including `high_score`. Pulses coincident with the reset are lost.

## Test plan
- Reset, start, 12 `game_tick` pulses (DIGITS=4, TICK_POINTS=1) → `score` = 0x0012, `active` = 1, `overflow` never set.
- Carry chain: at `score` 0x0095, `game_tick` + `bonus_valid` with `bonus_points` = 9 in the same cycle → 0x0105 after one edge. `bonus_points` = 4'hF at 0x0000 → 0x0009.
- SATURATE=1: at 0x9995, bonus 9 → `score` 0x9999 and a 1-cycle `overflow`. A further tick → still 0x9999 with another `overflow` pulse. A cycle with no add → no pulse.
- SATURATE=0: at 0x9998, tick + bonus 5 → `score` 0x0004 and a 1-cycle `overflow`.
- High score across three games:
  - Game 1 ends at 0x0042 → `high_score` 0x0042, `new_high` 1.
  - The next `game_start` clears `new_high`. Game 2 ends at 0x0030 → `high_score` 0x0042, `new_high` 0.
  - Game 3 ends at exactly 0x0042 → no update, `new_high` 0.
- Priority and reset cases:
  - In ACTIVE at 0x0007, `game_start` + `game_over` + tick in the same cycle → state OVER, `score` 0x0007, record compare done.
  - `game_over` while IDLE → ignored.
  - `rst_n` low mid-game → all outputs 0 asynchronously, before the next edge.
